// File: rtl/err_stats_collector.sv
// err_stats_collector: sum of squared error between a DUT sample stream and a
// reference stream over 2**SEQ_LOG2 accepted samples, with a held result.
// Optional build macro MAX_ERR_EN adds a peak absolute error tracker (res_max).
module err_stats_collector #(
    parameter int unsigned INPUT_WL  = 12,
    parameter int unsigned SEQ_LOG2  = 17,
    parameter int unsigned SIGNED_IN = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INPUT_WL-1:0] data_in,
    input  logic [INPUT_WL-1:0] data_ref,
    output logic                busy,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [63:0]         res_sum,
    output logic [INPUT_WL:0]   res_max
);

    localparam int unsigned DIFF_W = INPUT_WL + 1;
    localparam int unsigned SQ_W   = 2 * INPUT_WL + 2;
    localparam int unsigned ACC_W  = SQ_W + SEQ_LOG2;
    localparam int unsigned CNT_W  = SEQ_LOG2 + 1;
    localparam bit          SGN    = (SIGNED_IN != 0);
    localparam logic [CNT_W-1:0] LAST_CNT = {1'b0, {SEQ_LOG2{1'b1}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 drain_q, drain_d;
    logic                 s1_valid_q, s1_valid_d;
    logic [DIFF_W-1:0]    diff_q, diff_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [SQ_W-1:0]      sq_q, sq_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic                 res_valid_q, res_valid_d;
    logic [63:0]          res_sum_q, res_sum_d;

`ifdef MAX_ERR_EN
    logic [DIFF_W-1:0]    abs_q, abs_d;
    logic [DIFF_W-1:0]    max_q, max_d;
    logic [DIFF_W-1:0]    res_max_q, res_max_d;
    logic [DIFF_W-1:0]    abs_c;
`endif

    logic [DIFF_W-1:0]      in_ext_c;
    logic [DIFF_W-1:0]      ref_ext_c;
    logic [DIFF_W-1:0]      diff_c;
    logic signed [SQ_W-1:0] diff_wide_c;
    logic [SQ_W-1:0]        sq_c;
    logic                   accept_c;

    // Operand extension, S1 difference and S2 square
    assign in_ext_c    = {SGN & data_in[INPUT_WL-1], data_in};
    assign ref_ext_c   = {SGN & data_ref[INPUT_WL-1], data_ref};
    assign diff_c      = ref_ext_c - in_ext_c;
    assign diff_wide_c = SQ_W'($signed(diff_q));
    assign sq_c        = $unsigned(diff_wide_c * diff_wide_c);
    assign accept_c    = in_valid && (state_q == ACCUM);

`ifdef MAX_ERR_EN
    assign abs_c = diff_q[DIFF_W-1] ? ((~diff_q) + DIFF_W'(1)) : diff_q;
`endif

    // Next-state, counter, pipeline and result logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        drain_d     = drain_q;
        s1_valid_d  = accept_c;
        diff_d      = accept_c ? diff_c : diff_q;
        s2_valid_d  = s1_valid_q;
        sq_d        = sq_c;
        acc_d       = s2_valid_q ? (acc_q + ACC_W'(sq_q)) : acc_q;
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
`ifdef MAX_ERR_EN
        abs_d       = abs_c;
        max_d       = (s2_valid_q && (abs_q > max_q)) ? abs_q : max_q;
        res_max_d   = res_max_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ACCUM;
                    cnt_d      = '0;
                    acc_d      = '0;
                    s1_valid_d = 1'b0;
                    s2_valid_d = 1'b0;
`ifdef MAX_ERR_EN
                    max_d      = '0;
`endif
                end
            end
            ACCUM: begin
                if (accept_c) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = DRAIN;
                        drain_d = 1'b0;
                    end
                end
            end
            DRAIN: begin
                if (drain_q) begin
                    state_d     = DONE;
                    res_valid_d = 1'b1;
                    res_sum_d   = 64'(acc_d);
`ifdef MAX_ERR_EN
                    res_max_d   = max_d;
`endif
                end else begin
                    drain_d = 1'b1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d     = IDLE;
            res_valid_d = 1'b0;
            s1_valid_d  = 1'b0;
            s2_valid_d  = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            drain_q     <= 1'b0;
            s1_valid_q  <= 1'b0;
            diff_q      <= '0;
            s2_valid_q  <= 1'b0;
            sq_q        <= '0;
            acc_q       <= '0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
`ifdef MAX_ERR_EN
            abs_q       <= '0;
            max_q       <= '0;
            res_max_q   <= '0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            drain_q     <= drain_d;
            s1_valid_q  <= s1_valid_d;
            diff_q      <= diff_d;
            s2_valid_q  <= s2_valid_d;
            sq_q        <= sq_d;
            acc_q       <= acc_d;
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
`ifdef MAX_ERR_EN
            abs_q       <= abs_d;
            max_q       <= max_d;
            res_max_q   <= res_max_d;
`endif
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign busy      = (state_q != IDLE);
    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
`ifdef MAX_ERR_EN
    assign res_max   = res_max_q;
`else
    assign res_max   = '0;
`endif

endmodule

// File: tb/tb_err_stats_collector.sv
// Bench for err_stats_collector: signed and unsigned instances share stimulus;
// expected results come from a queue of accepted sample pairs.
module tb_err_stats_collector;

    localparam int unsigned W = 12;
    localparam int unsigned L = 4;
    localparam int          N = 16;

    logic         clk = 1'b0;
    logic         rst, start, abort, in_valid, res_ready;
    logic [W-1:0] data_in, data_ref;

    logic         s_in_ready, s_busy, s_res_valid;
    logic [63:0]  s_res_sum;
    logic [W:0]   s_res_max;
    logic         u_in_ready, u_busy, u_res_valid;
    logic [63:0]  u_res_sum;
    logic [W:0]   u_res_max;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] q_ref[$];
    logic [W-1:0] q_in[$];

    always #5 clk = ~clk;

    err_stats_collector #(.INPUT_WL(W), .SEQ_LOG2(L), .SIGNED_IN(1)) dut_s (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .data_in(data_in), .data_ref(data_ref),
        .busy(s_busy), .res_valid(s_res_valid), .res_ready(res_ready),
        .res_sum(s_res_sum), .res_max(s_res_max)
    );

    err_stats_collector #(.INPUT_WL(W), .SEQ_LOG2(L), .SIGNED_IN(0)) dut_u (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(u_in_ready),
        .data_in(data_in), .data_ref(data_ref),
        .busy(u_busy), .res_valid(u_res_valid), .res_ready(res_ready),
        .res_sum(u_res_sum), .res_max(u_res_max)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: sum of squares and peak |ref - in| over the accepted pairs
    task automatic model(input bit sgn, output longint sum, output longint mx);
        longint r, x, d;
        sum = 0;
        mx  = 0;
        foreach (q_ref[i]) begin
            r = sgn ? longint'($signed(q_ref[i])) : longint'(q_ref[i]);
            x = sgn ? longint'($signed(q_in[i]))  : longint'(q_in[i]);
            d = r - x;
            sum += d * d;
            if (d < 0) d = -d;
            if (d > mx) mx = d;
        end
    endtask

    task automatic check_state(input string tag, input logic r, input logic b, input logic v);
        check_eq({tag, ":s_in_ready"}, 64'(s_in_ready), 64'(r));
        check_eq({tag, ":s_busy"},     64'(s_busy),     64'(b));
        check_eq({tag, ":s_res_valid"},64'(s_res_valid),64'(v));
        check_eq({tag, ":u_in_ready"}, 64'(u_in_ready), 64'(r));
        check_eq({tag, ":u_busy"},     64'(u_busy),     64'(b));
        check_eq({tag, ":u_res_valid"},64'(u_res_valid),64'(v));
    endtask

    task automatic check_result(input string tag);
        longint es, ms, eu, mu;
        model(1'b1, es, ms);
        model(1'b0, eu, mu);
`ifndef MAX_ERR_EN
        ms = 0;
        mu = 0;
`endif
        check_eq({tag, ":s_res_sum"}, s_res_sum, 64'(es));
        check_eq({tag, ":s_res_max"}, 64'(s_res_max), 64'(ms));
        check_eq({tag, ":u_res_sum"}, u_res_sum, 64'(eu));
        check_eq({tag, ":u_res_max"}, 64'(u_res_max), 64'(mu));
    endtask

    // mode: 0 continuous, 1 every other cycle, 2 random gaps
    task automatic run(input int mode, input bit fixed, input logic [W-1:0] fref,
                       input logic [W-1:0] fin, input int abort_at,
                       input bit rst_drain, input int hold);
        int  cnt;
        int  cyc;
        bit  v;
        cnt = 0;
        cyc = 0;
        q_ref.delete();
        q_in.delete();
        check_state("idle", 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        while (cnt < N && cyc < 2000) begin
            check_state("accum", 1'b1, 1'b1, 1'b0);
            if (abort_at > 0 && cnt == abort_at) break;
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            in_valid = v;
            data_ref = fixed ? fref : W'($urandom_range(0, 4095));
            data_in  = fixed ? fin  : W'($urandom_range(0, 4095));
            if (v) begin
                q_ref.push_back(data_ref);
                q_in.push_back(data_in);
                cnt++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;

        if (abort_at > 0) begin
            abort    = 1'b1;
            in_valid = 1'b1;
            tick();
            abort    = 1'b0;
            in_valid = 1'b0;
            for (int i = 0; i < 5; i++) begin
                check_state("aborted", 1'b0, 1'b0, 1'b0);
                tick();
            end
            return;
        end

        check_eq("accept_budget", 64'(cnt), 64'(N));
        // a 17th sample offered during drain must be dropped
        in_valid = 1'b1;
        data_ref = W'($urandom_range(0, 4095));
        data_in  = W'($urandom_range(0, 4095));

        if (rst_drain) begin
            check_state("drain_pre_rst", 1'b0, 1'b1, 1'b0);
            rst = 1'b1;
            tick();
            rst      = 1'b0;
            in_valid = 1'b0;
            check_state("rst_in_drain", 1'b0, 1'b0, 1'b0);
            check_eq("rst_in_drain:s_res_sum", s_res_sum, 64'd0);
            check_eq("rst_in_drain:u_res_sum", u_res_sum, 64'd0);
            check_eq("rst_in_drain:s_res_max", 64'(s_res_max), 64'd0);
            for (int i = 0; i < 6; i++) begin
                tick();
                check_state("post_rst", 1'b0, 1'b0, 1'b0);
            end
            return;
        end

        check_state("drain1", 1'b0, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        check_state("drain2", 1'b0, 1'b1, 1'b0);
        tick();
        check_state("done_t3", 1'b0, 1'b1, 1'b1);
        check_result("done_t3");

        res_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            if (i == 3) start = 1'b1;
            tick();
            start = 1'b0;
            check_state("hold", 1'b0, 1'b1, 1'b1);
            check_result("hold");
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check_state("released", 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        res_ready = 1'b0;
        data_in   = '0;
        data_ref  = '0;
        tick();
        tick();
        check_state("reset", 1'b0, 1'b0, 1'b0);
        check_eq("reset:s_res_sum", s_res_sum, 64'd0);
        check_eq("reset:u_res_sum", u_res_sum, 64'd0);
        check_eq("reset:s_res_max", 64'(s_res_max), 64'd0);
        check_eq("reset:u_res_max", 64'(u_res_max), 64'd0);
        rst = 1'b0;
        tick();

        run(0, 1'b1, W'(100), W'(97), 0, 1'b0, 10);
        run(1, 1'b1, W'(100), W'(97), 0, 1'b0, 0);
        run(0, 1'b1, W'(2047), W'(12'h800), 0, 1'b0, 2);
        run(0, 1'b1, W'(12'h800), W'(2047), 0, 1'b0, 0);
        run(2, 1'b0, '0, '0, 0, 1'b0, 3);
        run(2, 1'b0, '0, '0, 0, 1'b0, 1);

        // abort has priority over a simultaneous start
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_state("abort_vs_start", 1'b0, 1'b0, 1'b0);
        tick();

        run(0, 1'b1, W'(100), W'(97), 8, 1'b0, 0);
        run(0, 1'b1, W'(5), W'(7), 0, 1'b0, 0);
        run(2, 1'b0, '0, '0, 0, 1'b1, 0);
        run(2, 1'b0, '0, '0, 0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/err_stats_collector.md
Name: err_stats_collector

Overview:
- Parametrised successor to the squared-error data collector used for word-length evaluation.
- Computes the sum of squared differences between a DUT output stream (`data_in`) and a reference stream (`data_ref`) over a run of 2**SEQ_LOG2 samples.
- Adds per-sample valid/ready flow control, selectable signedness, abort, and a held result with valid/ready handshake.
- Sits between the DUT/reference pair and the host readout path.

Parameters:
- INPUT_WL, 12: sample word length (bits).
- SEQ_LOG2, 17: log2 of samples per run. Requires 2*INPUT_WL+2+SEQ_LOG2 <= 64.
- SIGNED_IN, 1: 1 = inputs are two's complement; 0 = inputs are unsigned, zero-extended.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin a run. Honoured only in IDLE.
- abort  in  1  cancel any run; return to IDLE.
- in_valid  in  1  sample pair present.
- in_ready  out  1  block accepts a sample this cycle.
- data_in  in  INPUT_WL  DUT sample.
- data_ref  in  INPUT_WL  reference sample.
- busy  out  1  state is not IDLE.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- res_sum  out  64  sum of squared error, zero-extended.
- res_max  out  INPUT_WL+1  peak absolute error (MAX_ERR_EN only).

Behaviour:
- Reset and outputs:
  - rst is synchronous and active-high. Highest priority. Outputs reset to: in_ready=0, busy=0, res_valid=0, res_sum=0, res_max=0. State resets to IDLE.
  - All outputs are registered or derived from state only: in_ready = (state==ACCUM); busy = (state!=IDLE).
- States: IDLE, ACCUM, DRAIN, DONE.
  - IDLE: start -> ACCUM. On that edge, clear sample counter, accumulator, max and pipeline valids.
  - ACCUM: a sample is accepted when in_valid && in_ready. The counter increments per accept. On the accept that makes the count 2**SEQ_LOG2 -> DRAIN.
  - DRAIN: exactly 2 cycles, then -> DONE.
  - DONE: res_valid=1; res_sum and res_max are held stable. On res_valid && res_ready -> IDLE, res_valid=0.
- start outside IDLE is ignored, including in DONE. A new run needs a start after returning to IDLE.
- abort in any state -> IDLE next edge. Clears res_valid and the pipeline. abort beats start in the same cycle.
- Pipeline, with a valid bit per stage:
  - S1: diff = ref - in, INPUT_WL+1 bits signed. Operands are sign-extended when SIGNED_IN=1, zero-extended when SIGNED_IN=0.
  - S2: sq = diff*diff, 2*INPUT_WL+2 bits unsigned.
  - S3: acc += sq when S2 valid. acc is 2*INPUT_WL+2+SEQ_LOG2 bits and cannot overflow.
- Latency: last sample accepted in cycle T. It is in acc at T+3. res_valid is first high in cycle T+3, with res_sum = acc.
- Gaps in in_valid are allowed. Only accepted samples count. Samples offered while in_ready=0 are dropped, not counted.
- Counter is SEQ_LOG2+1 bits. No wrap inside a run.

Optional Feature:
- Macro MAX_ERR_EN.
  - Defined: S2 also registers |diff|. A running max register is cleared at start and updated alongside acc. res_max is held with res_sum in DONE.
  - Undefined: no max logic is compiled; res_max is tied to 0.

Test Plan:
- SEQ_LOG2=4, INPUT_WL=12, SIGNED_IN=1; ref=100, in=97 for 16 consecutive accepts -> res_sum=144, res_max=3 (MAX_ERR_EN), res_valid first high 3 cycles after the 16th accept.
- Same data, in_valid toggled every other cycle -> res_sum=144. in_ready low after the 16th accept. A 17th offered sample is not counted.
- SIGNED_IN=1, ref=2047, in=-2048 (0x800), 16 samples -> res_sum=268304400, res_max=4095. SIGNED_IN=0, same bit patterns (ref=2047, in=2048) -> diff=-1, res_sum=16, res_max=1.
- Hold res_ready=0 for 10 cycles in DONE and pulse start -> res_valid/res_sum stable, start ignored. res_ready=1 -> IDLE next cycle, busy=0.
- abort after 8 accepts -> IDLE next cycle, in_ready=0, no res_valid. A fresh start with ref=5, in=7 for 16 samples -> res_sum=64 (no residue).
- rst asserted during DRAIN -> all outputs 0 next cycle. No res_valid pulse follows.
